id_ctrl_stage: RTL and testbench

//  Registered MIPS ID-stage control unit for the 5-stage pipeline. Decodes the IF/ID instruction into

---
 rtl/id_ctrl_pkg.sv | 73 +++++++
 rtl/ctrl_field_decoder.sv | 155 +++++++++++++++
 rtl/id_ctrl_stage.sv | 120 ++++++++++++
 tb/tb_id_ctrl_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// Shared constants for the MIPS ID-stage control unit: opcodes, functs, ALU codes, bus bit indices.
// Latency: n/a (constants and one pure helper function).
// Backpressure: n/a.
package id_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_SLL   = 4'b0000;
  localparam logic [3:0] ALU_SRL   = 4'b0001;
  localparam logic [3:0] ALU_SRA   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_NOR   = 4'b0111;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_OTHER = 4'b1111;

  // Execute-bus bits are offsets above the alu_op field
  localparam int ALU_SRC    = 0;
  localparam int REG_DST    = 1;
  // Memory-bus bits
  localparam int MEM_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int BRANCH     = 2;
  localparam int BRANCH_NE  = 3;
  // Write-back-bus bits
  localparam int MEM_TO_REG = 0;
  localparam int REG_WRITE  = 1;

  localparam int LINK_REG = 31;

  // Instructions whose rt field is a source operand (for load-use detection)
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/ctrl_field_decoder.sv
// Combinational MIPS instruction decoder: instr -> execute/memory/write-back buses, illegal, jump, uses_rt.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the decode is registered.
// Ports: instr in; exec_bus/mem_bus/wb_bus, illegal, jump, uses_rt, rs/rt/rd out (link out with ID_CTRL_LINK_EN).
// Build option ID_CTRL_LINK_EN: JAL/JALR write the link register; otherwise they decode as J/JR.
module ctrl_field_decoder
  import id_ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH   = 4,
  parameter int MEM_BUS_WIDTH  = 4,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [31:0]               instr,
  output logic [ALU_OP_WIDTH+1:0]   exec_bus,
  output logic [MEM_BUS_WIDTH-1:0]  mem_bus,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus,
`ifdef ID_CTRL_LINK_EN
  output logic                      link,
`endif
  output logic                      illegal,
  output logic                      jump,
  output logic                      uses_rt,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [REG_ADDR_WIDTH-1:0] rd
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] alu;
  logic       alu_src, reg_dst, mem_write, mem_read, branch, branch_ne, mem_to_reg, reg_write;
  logic       link_i;
  logic [4:0] unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = instr[10:6];
  assign rs           = REG_ADDR_WIDTH'(instr[25:21]);
  assign rt           = REG_ADDR_WIDTH'(instr[20:16]);
  assign uses_rt      = reads_rt(opcode);

  always_comb begin
    alu        = ALU_OTHER;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    link_i     = 1'b0;
    jump       = 1'b0;
    illegal    = 1'b0;
    rd         = REG_ADDR_WIDTH'(instr[15:11]);
    case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          F_SLL, F_SLLV:  alu = ALU_SLL;
          F_SRL, F_SRLV:  alu = ALU_SRL;
          F_SRA, F_SRAV:  alu = ALU_SRA;
          F_ADD, F_ADDU:  alu = ALU_ADD;
          F_SUB, F_SUBU:  alu = ALU_SUB;
          F_AND:          alu = ALU_AND;
          F_OR:           alu = ALU_OR;
          F_XOR:          alu = ALU_XOR;
          F_NOR:          alu = ALU_NOR;
          F_SLT:          alu = ALU_SLT;
          F_JR: begin
            jump      = 1'b1;
            reg_write = 1'b0;
          end
          F_JALR: begin
            jump = 1'b1;
`ifdef ID_CTRL_LINK_EN
            link_i = 1'b1;
`else
            reg_write = 1'b0;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_J: jump = 1'b1;
      OP_JAL: begin
        jump = 1'b1;
        rd   = REG_ADDR_WIDTH'(LINK_REG);
`ifdef ID_CTRL_LINK_EN
        reg_dst   = 1'b1;   // steer the write to rd (= $31)
        reg_write = 1'b1;
        link_i    = 1'b1;
`endif
      end
      OP_BEQ, OP_BNE: begin
        alu       = ALU_SUB;
        branch    = 1'b1;
        branch_ne = opcode[0];
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        case (opcode)
          OP_SLTI: alu = ALU_SLT;
          OP_ANDI: alu = ALU_AND;
          OP_ORI:  alu = ALU_OR;
          OP_XORI: alu = ALU_XOR;
          default: alu = ALU_ADD;
        endcase
      end
      OP_LW: begin
        alu        = ALU_ADD;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      OP_SW: begin
        alu       = ALU_ADD;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    exec_bus = '0;
    mem_bus  = '0;
    wb_bus   = '0;
    // An undecodable instruction travels as an all-zero (bubble-like) control word
    if (!illegal) begin
      exec_bus[ALU_OP_WIDTH-1:0]      = ALU_OP_WIDTH'(alu);
      exec_bus[ALU_OP_WIDTH+ALU_SRC]  = alu_src;
      exec_bus[ALU_OP_WIDTH+REG_DST]  = reg_dst;
      mem_bus[MEM_WRITE]              = mem_write;
      mem_bus[MEM_READ]               = mem_read;
      mem_bus[BRANCH]                 = branch;
      mem_bus[BRANCH_NE]              = branch_ne;
      wb_bus[MEM_TO_REG]              = mem_to_reg;
      wb_bus[REG_WRITE]               = reg_write;
    end else begin
      jump   = 1'b0;
      link_i = 1'b0;
    end
  end

`ifdef ID_CTRL_LINK_EN
  assign link = link_i;
`else
  logic unused_link;
  assign unused_link = link_i;
`endif

endmodule

// File: rtl/id_ctrl_stage.sv
// MIPS ID stage control: decodes IF/ID, owns the ID/EX control register, load-use hazard and flush.
// Latency: 1 cycle from i_instr to o_* buses; o_stall/o_jump are combinational.
// Backpressure: i_stall_ext holds ID/EX; o_stall asks the front end to hold PC and IF/ID.
// Ports: clk, rst_n, i_valid, i_instr, i_flush, i_stall_ext in; o_stall, o_jump, o_valid, o_execute_bus,
//        o_memory_bus, o_wb_bus, o_rs, o_rt, o_rd, o_illegal out (o_link with ID_CTRL_LINK_EN).
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH   = 4,
  parameter int MEM_BUS_WIDTH  = 4,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [31:0]               i_instr,
  input  logic                      i_flush,
  input  logic                      i_stall_ext,
  output logic                      o_stall,
  output logic                      o_jump,
  output logic                      o_valid,
  output logic [ALU_OP_WIDTH+1:0]   o_execute_bus,
  output logic [MEM_BUS_WIDTH-1:0]  o_memory_bus,
  output logic [WB_BUS_WIDTH-1:0]   o_wb_bus,
  output logic [REG_ADDR_WIDTH-1:0] o_rs,
  output logic [REG_ADDR_WIDTH-1:0] o_rt,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
`ifdef ID_CTRL_LINK_EN
  output logic                      o_link,
`endif
  output logic                      o_illegal
);

  localparam int EXEC_BUS_WIDTH = ALU_OP_WIDTH + 2;

  logic [EXEC_BUS_WIDTH-1:0] dec_exec;
  logic [MEM_BUS_WIDTH-1:0]  dec_mem;
  logic [WB_BUS_WIDTH-1:0]   dec_wb;
  logic [REG_ADDR_WIDTH-1:0] dec_rs, dec_rt, dec_rd;
  logic                      dec_illegal, dec_jump, dec_uses_rt;
`ifdef ID_CTRL_LINK_EN
  logic                      dec_link;
`endif
  logic                      stall_q, hazard, load_decode;

  ctrl_field_decoder #(
    .ALU_OP_WIDTH  (ALU_OP_WIDTH),
    .MEM_BUS_WIDTH (MEM_BUS_WIDTH),
    .WB_BUS_WIDTH  (WB_BUS_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_dec (
    .instr   (i_instr),
    .exec_bus(dec_exec),
    .mem_bus (dec_mem),
    .wb_bus  (dec_wb),
`ifdef ID_CTRL_LINK_EN
    .link    (dec_link),
`endif
    .illegal (dec_illegal),
    .jump    (dec_jump),
    .uses_rt (dec_uses_rt),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .rd      (dec_rd)
  );

  always_comb begin
    hazard = i_valid && o_valid && o_memory_bus[MEM_READ] && (o_rt != '0) &&
             ((o_rt == dec_rs) || (dec_uses_rt && (o_rt == dec_rt)));
    // stall_q caps the hazard at one cycle even if ID/EX is held by i_stall_ext
    o_stall     = hazard && !i_flush && !stall_q;
    o_jump      = i_valid && dec_jump && !i_flush && !o_stall;
    load_decode = i_valid && !i_flush && !o_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q       <= 1'b0;
      o_valid       <= 1'b0;
      o_execute_bus <= '0;
      o_memory_bus  <= '0;
      o_wb_bus      <= '0;
      o_rs          <= '0;
      o_rt          <= '0;
      o_rd          <= '0;
      o_illegal     <= 1'b0;
`ifdef ID_CTRL_LINK_EN
      o_link        <= 1'b0;
`endif
    end else begin
      stall_q <= o_stall;
      if (!i_stall_ext) begin
        if (load_decode) begin
          o_valid       <= 1'b1;
          o_execute_bus <= dec_exec;
          o_memory_bus  <= dec_mem;
          o_wb_bus      <= dec_wb;
          o_rs          <= dec_rs;
          o_rt          <= dec_rt;
          o_rd          <= dec_rd;
          o_illegal     <= o_illegal | dec_illegal;
`ifdef ID_CTRL_LINK_EN
          o_link        <= dec_link;
`endif
        end else begin
          // Bubble: control cleared, specifiers left as they were
          o_valid       <= 1'b0;
          o_execute_bus <= '0;
          o_memory_bus  <= '0;
          o_wb_bus      <= '0;
`ifdef ID_CTRL_LINK_EN
          o_link        <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
module tb_id_ctrl_stage;

`ifdef ID_CTRL_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_instr = '0;
  logic        i_flush = 1'b0;
  logic        i_stall_ext = 1'b0;
  logic        o_stall, o_jump, o_valid, o_illegal;
  logic [5:0]  o_execute_bus;
  logic [3:0]  o_memory_bus;
  logic [1:0]  o_wb_bus;
  logic [4:0]  o_rs, o_rt, o_rd;
`ifdef ID_CTRL_LINK_EN
  logic        o_link;
`endif

  id_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_flush(i_flush),
    .i_stall_ext(i_stall_ext), .o_stall(o_stall), .o_jump(o_jump), .o_valid(o_valid),
    .o_execute_bus(o_execute_bus), .o_memory_bus(o_memory_bus), .o_wb_bus(o_wb_bus),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
`ifdef ID_CTRL_LINK_EN
    .o_link(o_link),
`endif
    .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       ok, jmp, urt;
    bit [5:0] exec;   // {reg_dst, alu_src, alu_op}
    bit [3:0] mem;    // {branch_ne, branch, mem_read, mem_write}
    bit [1:0] wb;     // {reg_write, mem_to_reg}
    bit [4:0] rd;
  } dec_t;

  // Instruction semantics from the ISA table: class -> control word
  function automatic dec_t ref_dec(input bit [31:0] ins);
    dec_t d;
    bit [5:0] op = ins[31:26];
    bit [5:0] fn = ins[5:0];
    bit [3:0] alu = 4'hF;
    d.ok = 1; d.jmp = 0; d.exec = 0; d.mem = 0; d.wb = 0;
    d.rd = ins[15:11];
    d.urt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5);
    if (op == 6'd0) begin
      case (fn)
        6'd0, 6'd4:   alu = 4'd0;
        6'd2, 6'd6:   alu = 4'd1;
        6'd3, 6'd7:   alu = 4'd2;
        6'd32, 6'd33: alu = 4'd3;
        6'd34, 6'd35: alu = 4'd8;
        6'd36:        alu = 4'd4;
        6'd37:        alu = 4'd5;
        6'd38:        alu = 4'd6;
        6'd39:        alu = 4'd7;
        6'd42:        alu = 4'd9;
        6'd8, 6'd9:   d.jmp = 1;
        default:      d.ok = 0;
      endcase
      d.exec = {2'b10, alu};
      d.wb   = (d.jmp && !(LINK && fn == 6'd9)) ? 2'b00 : 2'b10;
    end else begin
      case (op)
        6'd2:  begin d.jmp = 1; d.exec = 6'b001111; end
        6'd3:  begin d.jmp = 1; d.rd = 5'd31;
                 d.exec = LINK ? 6'b101111 : 6'b001111; d.wb = LINK ? 2'b10 : 2'b00; end
        6'd4:  begin d.exec = 6'b001000; d.mem = 4'b0100; end
        6'd5:  begin d.exec = 6'b001000; d.mem = 4'b1100; end
        6'd8, 6'd9: begin d.exec = 6'b010011; d.wb = 2'b10; end
        6'd10: begin d.exec = 6'b011001; d.wb = 2'b10; end
        6'd12: begin d.exec = 6'b010100; d.wb = 2'b10; end
        6'd13: begin d.exec = 6'b010101; d.wb = 2'b10; end
        6'd14: begin d.exec = 6'b010110; d.wb = 2'b10; end
        6'd35: begin d.exec = 6'b010011; d.mem = 4'b0010; d.wb = 2'b11; end
        6'd43: begin d.exec = 6'b010011; d.mem = 4'b0001; end
        default: d.ok = 0;
      endcase
    end
    if (!d.ok) begin d.exec = 0; d.mem = 0; d.wb = 0; d.jmp = 0; end
    return d;
  endfunction

  bit       m_valid, m_ill, m_prev;
  bit [5:0] m_exec;
  bit [3:0] m_mem;
  bit [1:0] m_wb;
  bit [4:0] m_rs, m_rt, m_rd;

  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_prev = 0; m_exec = 0; m_mem = 0; m_wb = 0;
    m_rs = 0; m_rt = 0; m_rd = 0;
  endtask

  task automatic check_regs();
    check("valid", o_valid, m_valid);
    check("exec", o_execute_bus, m_exec);
    check("mem", o_memory_bus, m_mem);
    check("wb", o_wb_bus, m_wb);
    check("rs", o_rs, m_rs);
    check("rt", o_rt, m_rt);
    check("rd", o_rd, m_rd);
    check("illegal", o_illegal, m_ill);
  endtask

  // One clock: drive at negedge, check combinational + registered outputs, advance model at posedge
  task automatic cycle(input bit v, input bit [31:0] ins, input bit fl, input bit se,
                       output bit st, output bit jp);
    dec_t d;
    bit es, ej;
    @(negedge clk);
    i_valid = v; i_instr = ins; i_flush = fl; i_stall_ext = se;
    #1;
    d  = ref_dec(ins);
    es = v && m_valid && m_mem[1] && (m_rt != 0) &&
         ((m_rt == ins[25:21]) || (d.urt && m_rt == ins[20:16])) && !fl && !m_prev;
    ej = v && d.jmp && !fl && !es;
    check("stall", o_stall, es);
    check("jump", o_jump, ej);
    check_regs();
    st = o_stall; jp = o_jump;
    @(posedge clk);
    if (!se) begin
      if (v && !fl && !es) begin
        m_valid = 1; m_exec = d.exec; m_mem = d.mem; m_wb = d.wb;
        m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = d.rd;
        if (!d.ok) m_ill = 1;
      end else begin
        m_valid = 0; m_exec = 0; m_mem = 0; m_wb = 0;
      end
    end
    m_prev = es;
  endtask

  function automatic bit [31:0] mk_r(input bit [4:0] rs, rt, rd, input bit [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic bit [31:0] mk_i(input bit [5:0] op, input bit [4:0] rs, rt, input bit [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic bit [31:0] rand_instr();
    bit [5:0] ops[13] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
    bit [5:0] fns[19] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9, 6'd32, 6'd33, 6'd34,
                          6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd42, 6'd32};
    bit [5:0] op = ops[$urandom_range(0, 12)];
    bit [5:0] fn = fns[$urandom_range(0, 18)];
    bit [4:0] rs = 5'($urandom_range(0, 3));
    bit [4:0] rt = 5'($urandom_range(0, 3));
    bit [4:0] rd = 5'($urandom_range(0, 31));
    bit [4:0] sh = 5'($urandom_range(0, 31));
    int k = $urandom_range(0, 29);
    if (k == 0) op = 6'h3F;
    if (k == 1) begin op = 6'd0; fn = 6'h3F; end
    return {op, rs, rt, rd, sh, fn};
  endfunction

  bit st, jp;
  bit [31:0] add3, lw5, add6, jr5;

  initial begin
    add3 = mk_r(5'd1, 5'd2, 5'd3, 6'd32);     // ADD $3,$1,$2 = 0x00221820
    lw5  = mk_i(6'd35, 5'd1, 5'd5, 16'd0);    // LW $5,0($1)
    add6 = mk_r(5'd5, 5'd2, 5'd6, 6'd32);     // ADD $6,$5,$2
    jr5  = mk_r(5'd5, 5'd0, 5'd0, 6'd8);      // JR $5
    model_reset();

    // Reset state
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_exec", o_execute_bus, 0);
    check("rst_illegal", o_illegal, 0);
    check("rst_stall", o_stall, 0);
    @(negedge clk); rst_n = 1'b1;

    // Plain decode
    cycle(1, add3, 0, 0, st, jp);
    #1;
    check("add_instr", add3, 32'h00221820);
    check("add_exec", o_execute_bus, 6'b100011);
    check("add_mem", o_memory_bus, 0);
    check("add_wb", o_wb_bus, 2'b10);
    check("add_rd", o_rd, 3);
    check("add_valid", o_valid, 1);

    // Illegal opcode, sticky flag
    cycle(1, {6'h3F, 26'd0}, 0, 0, st, jp);
    #1;
    check("ill_exec", o_execute_bus, 0);
    check("ill_wb", o_wb_bus, 0);
    check("ill_valid", o_valid, 1);
    check("ill_flag", o_illegal, 1);
    cycle(1, add3, 0, 0, st, jp);
    #1;
    check("ill_sticky", o_illegal, 1);

    // Load-use: one stall cycle, bubble, then the consumer is registered
    cycle(1, lw5, 0, 0, st, jp);
    cycle(1, add6, 0, 0, st, jp);
    check("lu_stall", st, 1);
    #1;
    check("lu_bubble", o_valid, 0);
    cycle(1, add6, 0, 0, st, jp);
    check("lu_stall_once", st, 0);
    #1;
    check("lu_add_valid", o_valid, 1);
    check("lu_add_rd", o_rd, 6);

    // Load to $0 never stalls
    cycle(1, mk_i(6'd35, 5'd1, 5'd0, 16'd4), 0, 0, st, jp);
    cycle(1, mk_r(5'd0, 5'd0, 5'd7, 6'd32), 0, 0, st, jp);
    check("lu_zero_nostall", st, 0);

    // Flush beats a hazard and kills the jump
    cycle(1, lw5, 0, 0, st, jp);
    cycle(1, jr5, 1, 0, st, jp);
    check("fl_stall", st, 0);
    check("fl_jump", jp, 0);
    #1;
    check("fl_bubble", o_valid, 0);

    // External stall holds ID/EX for 3 cycles, flush ignored meanwhile
    cycle(1, add3, 0, 0, st, jp);
    for (int k = 0; k < 3; k++) begin
      cycle(1, mk_i(6'd13, 5'd1, 5'd9, 16'h55), (k == 1), 1, st, jp);
      #1;
      check("xs_exec_hold", o_execute_bus, 6'b100011);
      check("xs_rd_hold", o_rd, 3);
      check("xs_valid_hold", o_valid, 1);
    end
    cycle(1, mk_i(6'd13, 5'd1, 5'd9, 16'h55), 1, 0, st, jp);
    #1;
    check("xs_flush_after", o_valid, 0);

    // Reset in the middle of a stall
    cycle(1, lw5, 0, 0, st, jp);
    @(negedge clk);
    i_valid = 1; i_instr = add6; i_flush = 0; i_stall_ext = 0;
    #1;
    check("mr_pre_stall", o_stall, 1);
    rst_n = 1'b0;
    #1;
    check("mr_stall", o_stall, 0);
    check("mr_valid", o_valid, 0);
    check("mr_mem", o_memory_bus, 0);
    check("mr_illegal", o_illegal, 0);
    check("mr_rt", o_rt, 0);
    model_reset();
    @(posedge clk); #2; rst_n = 1'b1;
    cycle(1, add6, 0, 0, st, jp);
    check("mr_no_stall", st, 0);
    #1;
    check("mr_decode", o_rd, 6);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 99) < 85), rand_instr(), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 10), st, jp);
    end
    @(negedge clk);
    #1;
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
